// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the peripheral bus master.
// Wait-register addresses are compared on bits [6:0] only.
package peripheral_bus_pkg;

    localparam int CMD_W = 17;

    localparam logic [6:0] ADDR_WAIT_VBLANK = 7'h00;
    localparam logic [6:0] ADDR_WAIT_HBLANK = 7'h02;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        SYNC_HOLD,
        SYNC_WAIT,
        RD0,
        RD1,
        RD2
    } bus_state_t;

    typedef struct packed {
        logic       read;
        logic [7:0] address;
        logic [7:0] data;
    } cmd_t;

    function automatic logic is_sync_addr(input logic [6:0] a);
        return (a == ADDR_WAIT_VBLANK) || (a == ADDR_WAIT_HBLANK);
    endfunction

endpackage

// File: rtl/peripheral_bus_master_cmd_fifo.sv
// Synchronous command FIFO with registered read data.
// head_msb exposes the tag bit of the oldest entry for routing.
module cmd_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             head_msb,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_msb = mem[rd_ptr][WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/peripheral_bus_master.sv
// Queued register-port initiator for a non-CPU agent.
// Replays FIFO commands onto the peripheral bus, stalling on wait_video.
module peripheral_bus_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             raw_clk,
    input  logic             reset,
    input  logic             cmd_push,
    input  logic             cmd_read,
    input  logic [7:0]       cmd_address,
    input  logic [7:0]       cmd_data,
    output logic             cmd_full,
    output logic [CNT_W-1:0] cmd_count,
    output logic             cmd_overflow,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             busy,
    output logic [7:0]       bus_address,
    output logic [7:0]       bus_data_out,
    output logic             bus_write_enable,
    output logic             bus_enable,
    input  logic [7:0]       bus_data_in,
    input  logic             wait_video
);

    import peripheral_bus_pkg::*;

    bus_state_t state;
    bus_state_t state_n;

    cmd_t cmd_q;
    logic head_read;
    logic fifo_empty;
    logic pop;
    logic issue;

    logic       en_q;
    logic       wr_q;
    logic       rd_valid_q;
    logic [7:0] rd_data_q;
    logic       overflow_q;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_cmd_fifo (
        .clk       (raw_clk),
        .reset     (reset),
        .push      (cmd_push),
        .push_data ({cmd_read, cmd_address, cmd_data}),
        .pop       (pop),
        .rd_data   (cmd_q),
        .head_msb  (head_read),
        .full      (cmd_full),
        .empty     (fifo_empty),
        .count     (cmd_count)
    );

    // Several states fall back to IDLE behaviour; issue marks those cycles.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        issue   = 1'b0;
        unique case (state)
            IDLE: issue = 1'b1;
            WR: begin
                if (!cmd_q.read && is_sync_addr(cmd_q.address[6:0])) begin
                    state_n = SYNC_HOLD;
                end else begin
                    issue = 1'b1;
                end
            end
            SYNC_HOLD: state_n = SYNC_WAIT;
            SYNC_WAIT: issue = !wait_video;
            RD0: state_n = RD1;
            RD1: state_n = RD2;
            RD2: issue = 1'b1;
            default: state_n = IDLE;
        endcase
        if (issue) begin
            state_n = IDLE;
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_n = head_read ? RD0 : WR;
            end
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state      <= IDLE;
            en_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_n;
            en_q       <= (state_n == WR) || (state_n == RD0);
            wr_q       <= (state_n == WR);
            rd_valid_q <= (state == RD2);
            if (state == RD1) begin
                rd_data_q <= bus_data_in;
            end
            // Full is judged before any same-cycle pop.
            if (cmd_push && cmd_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus_address      = cmd_q.address;
    assign bus_data_out     = cmd_q.data;
    assign bus_enable       = en_q;
    assign bus_write_enable = wr_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign cmd_overflow     = overflow_q;
    assign busy             = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Scoreboard bench for peripheral_bus_master.
// Expected strobes/reads are queued with their cycle; a monitor compares.
module tb_peripheral_bus_master;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             raw_clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_push = 1'b0;
    logic             cmd_read = 1'b0;
    logic [7:0]       cmd_address = 8'h00;
    logic [7:0]       cmd_data = 8'h00;
    logic             cmd_full;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_overflow;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             busy;
    logic [7:0]       bus_address;
    logic [7:0]       bus_data_out;
    logic             bus_write_enable;
    logic             bus_enable;
    logic [7:0]       bus_data_in;
    logic             wait_video = 1'b0;

    peripheral_bus_master #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .raw_clk          (raw_clk),
        .reset            (reset),
        .cmd_push         (cmd_push),
        .cmd_read         (cmd_read),
        .cmd_address      (cmd_address),
        .cmd_data         (cmd_data),
        .cmd_full         (cmd_full),
        .cmd_count        (cmd_count),
        .cmd_overflow     (cmd_overflow),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .busy             (busy),
        .bus_address      (bus_address),
        .bus_data_out     (bus_data_out),
        .bus_write_enable (bus_write_enable),
        .bus_enable       (bus_enable),
        .bus_data_in      (bus_data_in),
        .wait_video       (wait_video)
    );

    always #5 raw_clk = ~raw_clk;

    int cyc = 0;
    always @(posedge raw_clk) cyc <= cyc + 1;

    // Peripheral model: registers read data at the end of the enable cycle.
    logic [7:0] periph_q = 8'h00;
    always @(posedge raw_clk) begin
        if (bus_enable && !bus_write_enable)
            periph_q <= (bus_address == 8'h43) ? 8'h5A : 8'hEE;
    end
    assign bus_data_in = periph_q;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        int         at;
    } bus_exp_t;

    typedef struct {
        logic [7:0] data;
        int         at;
    } rd_exp_t;

    bus_exp_t bus_q[$];
    rd_exp_t  rd_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge raw_clk) begin
        bus_exp_t be;
        rd_exp_t  re;
        if (bus_write_enable && !bus_enable)
            check("we_without_enable", 32'(bus_write_enable), 32'd0);
        if (bus_enable) begin
            if (bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got addr 0x%0h we %0b at cycle %0d, required none",
                         bus_address, bus_write_enable, cyc);
            end else begin
                be = bus_q.pop_front();
                check("strobe_cycle", 32'(cyc), 32'(be.at));
                check("strobe_we", 32'(bus_write_enable), 32'(be.we));
                check("strobe_addr", 32'(bus_address), 32'(be.addr));
                if (be.we)
                    check("strobe_data", 32'(bus_data_out), 32'(be.data));
            end
        end
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid: got rd_data 0x%0h at cycle %0d, required none",
                         rd_data, cyc);
            end else begin
                re = rd_q.pop_front();
                check("rd_valid_cycle", 32'(cyc), 32'(re.at));
                check("rd_data", 32'(rd_data), 32'(re.data));
            end
        end
    end

    task automatic tick();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic push(input logic rd, input logic [7:0] a,
                        input logic [7:0] d);
        cmd_push    = 1'b1;
        cmd_read    = rd;
        cmd_address = a;
        cmd_data    = d;
        tick();
        cmd_push    = 1'b0;
        cmd_read    = 1'b0;
    endtask

    task automatic expect_bus(input logic we, input logic [7:0] a,
                              input logic [7:0] d, input int at);
        bus_q.push_back('{we: we, addr: a, data: d, at: at});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_enable"}, 32'(bus_enable), 32'd0);
        check({tag, "_bus_we"}, 32'(bus_write_enable), 32'd0);
        check({tag, "_bus_address"}, 32'(bus_address), 32'd0);
        check({tag, "_bus_data_out"}, 32'(bus_data_out), 32'd0);
        check({tag, "_cmd_count"}, 32'(cmd_count), 32'd0);
        check({tag, "_cmd_full"}, 32'(cmd_full), 32'd0);
        check({tag, "_cmd_overflow"}, 32'(cmd_overflow), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    int p;
    int q;

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Back-to-back writes: strobes at P+2 and P+3.
        p = cyc;
        expect_bus(1'b1, 8'h06, 8'h8A, p + 2);
        expect_bus(1'b1, 8'h08, 8'h1C, p + 3);
        push(1'b0, 8'h06, 8'h8A);
        push(1'b0, 8'h08, 8'h1C);
        check("t1_busy_mid", 32'(busy), 32'd1);
        repeat (2) tick();
        check("t1_busy_done", 32'(busy), 32'd0);
        repeat (3) tick();

        // HBLANK wait: wait_video high W+1..W+10, released at W+11.
        p = cyc;
        expect_bus(1'b1, 8'h02, 8'h00, p + 2);
        expect_bus(1'b1, 8'h09, 8'h44, p + 14);
        push(1'b0, 8'h02, 8'h00);
        push(1'b0, 8'h09, 8'h44);
        tick();
        wait_video = 1'b1;
        repeat (5) tick();
        check("t2_count_stalled", 32'(cmd_count), 32'd1);
        check("t2_busy_stalled", 32'(busy), 32'd1);
        repeat (5) tick();
        wait_video = 1'b0;
        repeat (5) tick();

        // 0x80 aliases VBLANK; wait_video stays low so SYNC_WAIT exits at once.
        p = cyc;
        expect_bus(1'b1, 8'h80, 8'h00, p + 2);
        expect_bus(1'b1, 8'h0A, 8'h55, p + 5);
        push(1'b0, 8'h80, 8'h00);
        push(1'b0, 8'h0A, 8'h55);
        repeat (5) tick();

        // Read: strobe at R, rd_valid at R+3, data held afterwards.
        p = cyc;
        expect_bus(1'b0, 8'h43, 8'h00, p + 2);
        rd_q.push_back('{data: 8'h5A, at: p + 5});
        push(1'b1, 8'h43, 8'h00);
        repeat (25) tick();
        check("t4_rd_data_held", 32'(rd_data), 32'h5A);
        check("t4_no_overflow", 32'(cmd_overflow), 32'd0);

        // Overflow while stalled in SYNC_WAIT.
        p = cyc;
        expect_bus(1'b1, 8'h00, 8'h00, p + 2);
        push(1'b0, 8'h00, 8'h00);
        repeat (2) tick();
        wait_video = 1'b1;
        for (int i = 0; i < 17; i++)
            push(1'b0, 8'(8'h10 + i), 8'(8'hA0 + i));
        check("t5_full", 32'(cmd_full), 32'd1);
        check("t5_count", 32'(cmd_count), 32'd16);
        check("t5_overflow", 32'(cmd_overflow), 32'd1);
        repeat (3) tick();
        check("t5_count_hold", 32'(cmd_count), 32'd16);
        q = cyc;
        for (int i = 0; i < 16; i++)
            expect_bus(1'b1, 8'(8'h10 + i), 8'(8'hA0 + i), q + 1 + i);
        wait_video = 1'b0;
        repeat (18) tick();
        check("t5_drained", 32'(cmd_count), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_overflow_sticky", 32'(cmd_overflow), 32'd1);

        // Reset during SYNC_WAIT with 5 queued.
        p = cyc;
        expect_bus(1'b1, 8'h02, 8'h00, p + 2);
        push(1'b0, 8'h02, 8'h00);
        repeat (2) tick();
        wait_video = 1'b1;
        for (int i = 0; i < 5; i++)
            push(1'b0, 8'(8'h30 + i), 8'(i));
        check("t6_count_before", 32'(cmd_count), 32'd5);
        reset = 1'b1;
        tick();
        check_all_zero("t6");
        reset = 1'b0;
        wait_video = 1'b0;
        repeat (20) tick();

        check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
